// File: rtl/btb_pkg.sv
// Shared types for the fetch redirect controller: PC geometry, FSM states and
// the in-flight prediction record.
package btb_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        REFILL
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            hit;
        logic [XLEN-1:0] pred_next;
    } entry_t;

    function automatic logic [XLEN-1:0] seq_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch/execute/BTB signal bundle seen by the redirect controller.
// The controller is the slave; the environment (fetch + execute) is the master.
interface fetch_redirect_ctrl_if #(parameter int unsigned CNT_W = 32);
    import btb_pkg::*;

    logic             fetch_valid;
    logic [XLEN-1:0]  fetch_pc;
    logic             fetch_btb_hit;
    logic [XLEN-1:0]  fetch_pred_pc;
    logic             resolve_valid;
    logic             resolve_is_branch;
    logic             resolve_taken;
    logic [XLEN-1:0]  resolve_target;
    logic             stall;
    logic             flush;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             btb_wr_en;
    logic [XLEN-1:0]  btb_wr_pc;
    logic [XLEN-1:0]  btb_wr_target;
    logic [CNT_W-1:0] cnt_branches;
    logic [CNT_W-1:0] cnt_hits;
    logic [CNT_W-1:0] cnt_correct;
    logic [CNT_W-1:0] cnt_mispredict;
    logic             err_underflow;

    modport master (
        output fetch_valid, fetch_pc, fetch_btb_hit, fetch_pred_pc,
               resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        input  stall, flush, redirect_valid, redirect_pc,
               btb_wr_en, btb_wr_pc, btb_wr_target,
               cnt_branches, cnt_hits, cnt_correct, cnt_mispredict, err_underflow
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_btb_hit, fetch_pred_pc,
               resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        output stall, flush, redirect_valid, redirect_pc,
               btb_wr_en, btb_wr_pc, btb_wr_target,
               cnt_branches, cnt_hits, cnt_correct, cnt_mispredict, err_underflow
    );

endinterface

// File: rtl/pred_queue.sv
// In-flight prediction FIFO: one entry per fetched instruction, popped in order
// as execute resolves them. Clear wins over push/pop.
module pred_queue
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   clear_i,
    input  entry_t push_data_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t         mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Checks each resolved instruction against its BTB prediction, drives the
// flush/redirect sequence, BTB training writes and prediction statistics.
module fetch_redirect_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input logic                  clk,
    input logic                  reset,
    fetch_redirect_ctrl_if.slave bus
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

    state_e           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             q_full, q_empty;
    entry_t           head, push_entry;
    logic             running, stall_c, do_push, resolve_ok, underflow;
    logic             mispredict, btb_upd;
    logic [XLEN-1:0]  actual_next;
    logic [3:0]       cnt_inc;

    logic             flush_q, redirect_valid_q, btb_wr_en_q, err_q;
    logic [XLEN-1:0]  redirect_pc_q, btb_wr_pc_q, btb_wr_target_q;
    logic [CNT_W-1:0] cnt_q [4];

    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (do_push),
        .pop_i       (resolve_ok),
        .clear_i     (mispredict),
        .push_data_i (push_entry),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .head_o      (head)
    );

    // Resolve compare; a mispredict also discards any fetch in the same cycle.
    always_comb begin
        running     = (state_q == RUN);
        stall_c     = q_full || !running;
        resolve_ok  = running && bus.resolve_valid && !q_empty;
        underflow   = running && bus.resolve_valid && q_empty;
        actual_next = (bus.resolve_is_branch && bus.resolve_taken) ? bus.resolve_target
                                                                   : seq_next(head.pc);
        mispredict  = resolve_ok && (actual_next != head.pred_next);
        btb_upd     = resolve_ok && bus.resolve_is_branch && bus.resolve_taken
                      && (!head.hit || (head.pred_next != bus.resolve_target));
        do_push     = bus.fetch_valid && !stall_c && !mispredict;
        push_entry  = '{pc:        bus.fetch_pc,
                        hit:       bus.fetch_btb_hit,
                        pred_next: bus.fetch_btb_hit ? bus.fetch_pred_pc : seq_next(bus.fetch_pc)};
        cnt_inc[0]  = resolve_ok && bus.resolve_is_branch;
        cnt_inc[1]  = resolve_ok && bus.resolve_is_branch && head.hit;
        cnt_inc[2]  = resolve_ok && bus.resolve_is_branch && !mispredict;
        cnt_inc[3]  = mispredict;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // fcnt counts flush cycles starting at 1 on the first cycle in FLUSH.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_W'(1);
                end
            end
            FLUSH: begin
                if (fcnt_q == FC_W'(FLUSH_CYCLES)) state_d = REFILL;
                else                               fcnt_d  = fcnt_q + FC_W'(1);
            end
            REFILL:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            btb_wr_en_q      <= 1'b0;
            btb_wr_pc_q      <= '0;
            btb_wr_target_q  <= '0;
            err_q            <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            flush_q          <= (state_d == FLUSH);
            redirect_valid_q <= mispredict;
            btb_wr_en_q      <= btb_upd;
            err_q            <= err_q || underflow;
            if (mispredict) redirect_pc_q <= actual_next;
            if (btb_upd) begin
                btb_wr_pc_q     <= head.pc;
                btb_wr_target_q <= bus.resolve_target;
            end
            for (int i = 0; i < 4; i++) begin
                if (cnt_inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign bus.stall          = stall_c;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.btb_wr_en      = btb_wr_en_q;
    assign bus.btb_wr_pc      = btb_wr_pc_q;
    assign bus.btb_wr_target  = btb_wr_target_q;
    assign bus.cnt_branches   = cnt_q[0];
    assign bus.cnt_hits       = cnt_q[1];
    assign bus.cnt_correct    = cnt_q[2];
    assign bus.cnt_mispredict = cnt_q[3];
    assign bus.err_underflow  = err_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table, hand-written corner
// sequences and a random run, all tracked by a queue-based reference model.
module tb_fetch_redirect_ctrl;

    localparam int DEPTH = 4;
    localparam int FC    = 2;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.CNT_W(CNT_W)) bus ();

    fetch_redirect_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred_next;
    } ment_t;

    ment_t       mq[$];
    int          blk;              // remaining non-RUN cycles after a mispredict
    logic        m_rv, m_bw, m_err;
    logic [31:0] m_rpc, m_bpc, m_btgt;
    logic [31:0] m_cnt [4];

    function automatic void m_reset();
        mq.delete();
        blk   = 0;
        m_rv  = 1'b0;
        m_bw  = 1'b0;
        m_err = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = '0;
    endfunction

    function automatic void m_inc(input int k);
        if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
    endfunction

    function automatic void m_step();
        logic        stall_pre, mis, br, tk;
        logic [31:0] actual;
        ment_t       h, e;
        if (rst) begin
            m_reset();
            return;
        end
        mis       = 1'b0;
        m_rv      = 1'b0;
        m_bw      = 1'b0;
        stall_pre = (mq.size() == DEPTH) || (blk > 0);
        br        = bus.resolve_is_branch;
        tk        = bus.resolve_taken;
        if (blk > 0) begin
            blk--;
            return;
        end
        if (bus.resolve_valid) begin
            if (mq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                h      = mq.pop_front();
                actual = (br && tk) ? bus.resolve_target : h.pc + 32'd4;
                mis    = (actual != h.pred_next);
                if (br) begin
                    m_inc(0);
                    if (h.hit) m_inc(1);
                    if (!mis)  m_inc(2);
                end
                if (mis) m_inc(3);
                if (br && tk && (!h.hit || h.pred_next != bus.resolve_target)) begin
                    m_bw   = 1'b1;
                    m_bpc  = h.pc;
                    m_btgt = bus.resolve_target;
                end
                if (mis) begin
                    mq.delete();
                    m_rv  = 1'b1;
                    m_rpc = actual;
                    blk   = FC + 1;
                end
            end
        end
        if (bus.fetch_valid && !stall_pre && !mis) begin
            e.pc        = bus.fetch_pc;
            e.hit       = bus.fetch_btb_hit;
            e.pred_next = bus.fetch_btb_hit ? bus.fetch_pred_pc : bus.fetch_pc + 32'd4;
            mq.push_back(e);
        end
    endfunction

    function automatic logic m_stall();
        return (mq.size() == DEPTH) || (blk > 0);
    endfunction

    task automatic check_all();
        chk1("stall", bus.stall, m_stall());
        chk1("flush", bus.flush, blk > 1);
        chk1("redirect_valid", bus.redirect_valid, m_rv);
        if (m_rv) chk32("redirect_pc", bus.redirect_pc, m_rpc);
        chk1("btb_wr_en", bus.btb_wr_en, m_bw);
        if (m_bw) begin
            chk32("btb_wr_pc", bus.btb_wr_pc, m_bpc);
            chk32("btb_wr_target", bus.btb_wr_target, m_btgt);
        end
        chk32("cnt_branches", bus.cnt_branches, m_cnt[0]);
        chk32("cnt_hits", bus.cnt_hits, m_cnt[1]);
        chk32("cnt_correct", bus.cnt_correct, m_cnt[2]);
        chk32("cnt_mispredict", bus.cnt_mispredict, m_cnt[3]);
        chk1("err_underflow", bus.err_underflow, m_err);
    endtask

    // Inputs are already driven (at a negedge); advance one clock and check.
    task automatic cycle();
        m_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic fv, input logic [31:0] fpc, input logic fh,
                         input logic [31:0] fp, input logic rv, input logic rb,
                         input logic rt, input logic [31:0] rtg);
        bus.fetch_valid       = fv;
        bus.fetch_pc          = fpc;
        bus.fetch_btb_hit     = fh;
        bus.fetch_pred_pc     = fp;
        bus.resolve_valid     = rv;
        bus.resolve_is_branch = rb;
        bus.resolve_taken     = rt;
        bus.resolve_target    = rtg;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cycle();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        fh;
        logic [31:0] fp;
        logic        rv, rb, rt;
        logic [31:0] rtg;
        logic        e_stall, e_flush, e_rv;
        logic [31:0] e_rpc;
        logic        e_bw;
        logic [31:0] e_bpc, e_btgt;
    } vec_t;

    vec_t tv [12];

    // ---------------- program-trace helpers for the loop test ----------------
    logic [31:0] btb [logic [31:0]];

    task automatic exec_instr(input logic [31:0] pc, input logic is_br,
                              input logic taken, input logic [31:0] tgt);
        logic        hit;
        logic [31:0] pred;
        for (int g = 0; g < 10 && m_stall(); g++) begin
            idle();
            cycle();
        end
        hit  = btb.exists(pc);
        pred = hit ? btb[pc] : 32'h0;
        drive(1'b1, pc, hit, pred, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, is_br, taken, tgt);
        cycle();
        if (m_bw) btb[m_bpc] = m_btgt;
    endtask

    task automatic run_program();
        logic [31:0] base;
        for (int l = 0; l < 4; l++) begin
            base = 32'h04 + 32'(l) * 32'h20;
            for (int it = 0; it < 5; it++) begin
                for (int o = 0; o <= 16; o += 4) begin
                    exec_instr(base + 32'(o), o == 16, it < 4, base);
                end
            end
            if (l < 3) begin
                for (int o = 20; o <= 28; o += 4) exec_instr(base + 32'(o), 1'b0, 1'b0, 32'h0);
            end
        end
        idle();
    endtask

    initial begin
        logic [31:0] mis_start;

        tv[0]  = '{1'b1, 32'h14, 1'b1, 32'h04, 1'b0, 1'b0, 1'b0, 32'h00,
                   1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[1]  = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h04,
                   1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[2]  = '{1'b1, 32'h34, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00,
                   1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[3]  = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h24,
                   1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h34, 32'h24};
        tv[4]  = '{1'b1, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h40,
                   1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[5]  = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00,
                   1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[6]  = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00,
                   1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[7]  = '{1'b1, 32'h54, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h00,
                   1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[8]  = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h44,
                   1'b1, 1'b1, 1'b1, 32'h58, 1'b0, 32'h00, 32'h00};
        tv[9]  = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00,
                   1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[10] = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00,
                   1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tv[11] = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00,
                   1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};

        m_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        do_reset();
        chk1("reset_flush", bus.flush, 1'b0);
        chk1("reset_stall", bus.stall, 1'b0);
        chk32("reset_cnt_branches", bus.cnt_branches, 32'd0);

        // Directed: correct taken, cold miss, loop exit.
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].fv, tv[i].fpc, tv[i].fh, tv[i].fp,
                  tv[i].rv, tv[i].rb, tv[i].rt, tv[i].rtg);
            cycle();
            chk1($sformatf("vec%0d_stall", i), bus.stall, tv[i].e_stall);
            chk1($sformatf("vec%0d_flush", i), bus.flush, tv[i].e_flush);
            chk1($sformatf("vec%0d_redirect_valid", i), bus.redirect_valid, tv[i].e_rv);
            if (tv[i].e_rv) chk32($sformatf("vec%0d_redirect_pc", i), bus.redirect_pc, tv[i].e_rpc);
            chk1($sformatf("vec%0d_btb_wr_en", i), bus.btb_wr_en, tv[i].e_bw);
            if (tv[i].e_bw) begin
                chk32($sformatf("vec%0d_btb_wr_pc", i), bus.btb_wr_pc, tv[i].e_bpc);
                chk32($sformatf("vec%0d_btb_wr_target", i), bus.btb_wr_target, tv[i].e_btgt);
            end
        end
        chk32("dir_cnt_branches", bus.cnt_branches, 32'd3);
        chk32("dir_cnt_hits", bus.cnt_hits, 32'd2);
        chk32("dir_cnt_correct", bus.cnt_correct, 32'd1);
        chk32("dir_cnt_mispredict", bus.cnt_mispredict, 32'd2);
        chk1("dir_err_underflow", bus.err_underflow, 1'b0);

        // Full queue: 5th fetch must be dropped, so the 5th resolve underflows.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i) * 32'd4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            cycle();
        end
        chk1("full_stall", bus.stall, 1'b1);
        drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        chk1("stall_after_pop", bus.stall, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk1("fifth_not_pushed_no_err", bus.err_underflow, 1'b0);
        cycle();
        chk1("fifth_not_pushed_err", bus.err_underflow, 1'b1);

        // Reset during FLUSH, then resolve on an empty queue.
        do_reset();
        drive(1'b1, 32'h34, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h24);
        cycle();
        chk1("pre_reset_flush", bus.flush, 1'b1);
        do_reset();
        chk1("midflush_reset_flush", bus.flush, 1'b0);
        chk1("midflush_reset_stall", bus.stall, 1'b0);
        chk32("midflush_reset_cnt_mispredict", bus.cnt_mispredict, 32'd0);
        chk32("midflush_reset_cnt_branches", bus.cnt_branches, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        chk1("underflow_err", bus.err_underflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(i) * 32'd4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            cycle();
            chk1($sformatf("underflow_count_stall%0d", i), bus.stall, i == 3);
        end

        // Back-to-back loops, two passes sharing the trained BTB.
        do_reset();
        btb.delete();
        mis_start = bus.cnt_mispredict;
        run_program();
        chk32("pass1_mispredicts", bus.cnt_mispredict - mis_start, 32'd8);
        mis_start = bus.cnt_mispredict;
        run_program();
        chk32("pass2_mispredicts", bus.cnt_mispredict - mis_start, 32'd4);
        chk1("loops_err_underflow", bus.err_underflow, 1'b0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) * 32'd4,
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) * 32'd4,
                  ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) * 32'd4);
            cycle();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
